// File: rtl/tx_pkt_fifo.sv
// Transmit packet FIFO: stores each packet as one byte-count header word
// followed by its data words. The reader only sees a packet after its eop
// has been accepted and the header has been filled in.
// Optional build macro TX_PKT_FIFO_DROP_CNT_EN adds the tx_drop_cnt output,
// which counts aborted and oversize packets.
//
// state  | meaning
// S_IDLE | waiting for a sop word; wr_ptr equals commit_ptr
// S_PKT  | packet in progress, header slot reserved at hdr_ptr
// S_DROP | oversize packet, words discarded until eop
module tx_pkt_fifo #(
   parameter int DEPTH_LOG2 = 11,
   parameter int MAX_BYTES  = 9600
) (
   input  logic        x_clk,
   input  logic        usr_rst,
   input  logic        usr_valid,
   output logic        usr_ready,
   input  logic [63:0] usr_data,
   input  logic        usr_sop,
   input  logic        usr_eop,
   input  logic [2:0]  usr_last_bytes,
   output logic [63:0] txfifo_dout,
   output logic        txfifo_empty,
   input  logic        txfifo_rd_en,
   output logic [31:0] tx_pkt_cnt
`ifdef TX_PKT_FIFO_DROP_CNT_EN
   ,
   output logic [31:0] tx_drop_cnt
`endif
);

   localparam int AW = DEPTH_LOG2;
   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_W = PW'(1) << DEPTH_LOG2;
   localparam logic [PW-1:0] P_ONE   = PW'(1);
   localparam logic [PW-1:0] P_TWO   = PW'(2);
   localparam logic [AW-1:0] A_ONE   = AW'(1);
   localparam logic [16:0]   MAX_B   = 17'(MAX_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] hdr_ptr_q, hdr_ptr_d;
   logic [15:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]   pkt_cnt_q, pkt_cnt_d;
   logic [63:0]   mem_q [2**DEPTH_LOG2];

   logic          accept;
   logic          rd_fire;
   logic          ptr_empty;
   logic [PW-1:0] used;
   logic [PW-1:0] free;
   logic [16:0]   word_bytes;
   logic [16:0]   sum;
   logic          data_we;
   logic [AW-1:0] data_addr;
   logic          hdr_we;
   logic          drop_inc;

   assign used       = wr_ptr_q - rd_ptr_q;
   assign free       = DEPTH_W - used;
   assign usr_ready  = !usr_rst && ((free >= P_TWO) || (state_q == S_DROP));
   assign accept     = usr_valid && usr_ready;
   assign ptr_empty  = (rd_ptr_q == commit_ptr_q);
   assign txfifo_empty = usr_rst || ptr_empty;
   assign rd_fire    = txfifo_rd_en && !txfifo_empty;
   assign txfifo_dout  = txfifo_empty ? 64'd0 : mem_q[rd_ptr_q[AW-1:0]];
   assign tx_pkt_cnt = pkt_cnt_q;
   assign word_bytes = (usr_eop && (usr_last_bytes != 3'd0)) ? {14'd0, usr_last_bytes} : 17'd8;
   assign sum        = {1'b0, byte_cnt_q} + word_bytes;

   // Write-side FSM: pointer moves, header bookkeeping and drop decisions
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      hdr_ptr_d    = hdr_ptr_q;
      byte_cnt_d   = byte_cnt_q;
      pkt_cnt_d    = pkt_cnt_q;
      rd_ptr_d     = rd_fire ? rd_ptr_q + P_ONE : rd_ptr_q;
      data_we      = 1'b0;
      data_addr    = wr_ptr_q[AW-1:0];
      hdr_we       = 1'b0;
      drop_inc     = 1'b0;
      if (accept) begin
         case (state_q)
            S_IDLE, S_PKT: begin
               if (usr_sop) begin
                  // A new sop always restarts at the last committed boundary,
                  // which discards any packet still in progress.
                  if (state_q == S_PKT) drop_inc = 1'b1;
                  if (word_bytes > MAX_B) begin
                     drop_inc = 1'b1;
                     wr_ptr_d = commit_ptr_q;
                     state_d  = usr_eop ? S_IDLE : S_DROP;
                  end else begin
                     hdr_ptr_d  = commit_ptr_q[AW-1:0];
                     data_we    = 1'b1;
                     data_addr  = commit_ptr_q[AW-1:0] + A_ONE;
                     wr_ptr_d   = commit_ptr_q + P_TWO;
                     byte_cnt_d = word_bytes[15:0];
                     if (usr_eop) begin
                        hdr_we       = 1'b1;
                        commit_ptr_d = commit_ptr_q + P_TWO;
                        pkt_cnt_d    = pkt_cnt_q + 32'd1;
                        state_d      = S_IDLE;
                     end else begin
                        state_d = S_PKT;
                     end
                  end
               end else if (state_q == S_PKT) begin
                  if (sum > MAX_B) begin
                     drop_inc = 1'b1;
                     wr_ptr_d = commit_ptr_q;
                     state_d  = usr_eop ? S_IDLE : S_DROP;
                  end else begin
                     data_we    = 1'b1;
                     data_addr  = wr_ptr_q[AW-1:0];
                     wr_ptr_d   = wr_ptr_q + P_ONE;
                     byte_cnt_d = sum[15:0];
                     if (usr_eop) begin
                        hdr_we       = 1'b1;
                        commit_ptr_d = wr_ptr_q + P_ONE;
                        pkt_cnt_d    = pkt_cnt_q + 32'd1;
                        state_d      = S_IDLE;
                     end
                  end
               end
            end
            S_DROP: begin
               if (usr_eop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and pointer registers
   always_ff @(posedge x_clk) begin
      if (usr_rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         hdr_ptr_q    <= '0;
         byte_cnt_q   <= '0;
         pkt_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         hdr_ptr_q    <= hdr_ptr_d;
         byte_cnt_q   <= byte_cnt_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

   // Packet RAM: data port and header back-fill port, contents not reset
   always_ff @(posedge x_clk) begin
      if (data_we) mem_q[data_addr] <= usr_data;
      if (hdr_we)  mem_q[hdr_ptr_d] <= {48'd0, byte_cnt_d};
   end

`ifdef TX_PKT_FIFO_DROP_CNT_EN
   logic [31:0] drop_cnt_q;

   // Count of aborted and oversize packets
   always_ff @(posedge x_clk) begin
      if (usr_rst)       drop_cnt_q <= '0;
      else if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
   end

   assign tx_drop_cnt = drop_cnt_q;
`else
   logic unused_drop_inc;
   assign unused_drop_inc = drop_inc;
`endif

endmodule
